// File: rtl/control_unit_idex.sv
// control_unit_idex: RV32I decode control plus ID/EX control register; optional IllegalE via ILLEGAL_TRAP_EN
module control_unit_idex #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] InstrD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ZeroE,
    output logic [1:0]      ImmSrcD,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic            ValidE,
`ifdef ILLEGAL_TRAP_EN
    output logic            PCSrcE,
    output logic            IllegalE
`else
    output logic            PCSrcE
`endif
);
    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       aluSrc;
        logic [2:0] aluControl;
    } ctrl_t;

    ctrl_t      ctrlD, ctrlE;
    logic       illegalD;
    logic [2:0] aluRI;
    logic       f3RI;
    logic [6:0] op;
    logic [2:0] f3;
    logic       unusedBits;

    assign op = InstrD[6:0];
    assign f3 = InstrD[14:12];
    assign unusedBits = ^{InstrD[31], InstrD[29:15], InstrD[11:7]};

    // decode opcode/funct3 into controls; any unsupported encoding collapses to a bubble
    always_comb begin
        ctrlD = '0;
        ImmSrcD = 2'b00;
        illegalD = 1'b0;
        aluRI = (f3 == 3'b111) ? 3'b010 : (f3 == 3'b110) ? 3'b011 : {2'b00, (op == 7'b0110011) & InstrD[30]};
        f3RI = (f3 == 3'b000) | (f3 == 3'b110) | (f3 == 3'b111);
        case (op)
            7'b0000011: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc = 1'b1;
                ctrlD.resultSrc = 2'b01;
                illegalD = f3 != 3'b010;
            end
            7'b0100011: begin
                ctrlD.memWrite = 1'b1;
                ctrlD.aluSrc = 1'b1;
                ImmSrcD = 2'b01;
                illegalD = f3 != 3'b010;
            end
            7'b0110011: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluControl = aluRI;
                illegalD = !f3RI;
            end
            7'b0010011: begin
                ctrlD.regWrite = 1'b1;
                ctrlD.aluSrc = 1'b1;
                ctrlD.aluControl = aluRI;
                illegalD = !f3RI;
            end
            7'b1100011: begin
                ctrlD.branch = 1'b1;
                ctrlD.aluControl = 3'b001;
                ImmSrcD = 2'b10;
                illegalD = f3 != 3'b000;
            end
            7'b1101111: begin
                ctrlD.jump = 1'b1;
                ctrlD.regWrite = 1'b1;
                ctrlD.resultSrc = 2'b10;
                ImmSrcD = 2'b11;
            end
            default: illegalD = 1'b1;
        endcase
        if (illegalD) begin
            ctrlD = '0;
            ImmSrcD = 2'b00;
        end
    end

    // ID/EX register: reset > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrlE <= '0;
            ValidE <= 1'b0;
        end else if (FlushE) begin
            ctrlE <= '0;
            ValidE <= 1'b0;
        end else if (!StallE) begin
            ctrlE <= ctrlD;
            ValidE <= !illegalD;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // trap flag for an illegal instruction, same priority as the control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) IllegalE <= 1'b0;
        else if (FlushE) IllegalE <= 1'b0;
        else if (!StallE) IllegalE <= illegalD;
    end
`endif

    assign RegWriteE = ctrlE.regWrite;
    assign ResultSrcE = ctrlE.resultSrc;
    assign MemWriteE = ctrlE.memWrite;
    assign JumpE = ctrlE.jump;
    assign BranchE = ctrlE.branch;
    assign ALUSrcE = ctrlE.aluSrc;
    assign ALUControlE = ctrlE.aluControl;
    assign PCSrcE = ValidE & (ctrlE.jump | (ctrlE.branch & ZeroE));
endmodule

// File: tb/tb_control_unit_idex.sv
// tb_control_unit_idex: scoreboard bench for control_unit_idex against a mnemonic-level model
module tb_control_unit_idex;
    logic        clk = 0, rst = 1;
    logic [31:0] InstrD = 0;
    logic        StallE = 0, FlushE = 0, ZeroE = 0;
    logic [1:0]  ImmSrcD, ResultSrcE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE, PCSrcE;
    logic [2:0]  ALUControlE;
`ifdef ILLEGAL_TRAP_EN
    logic        IllegalE;
`endif
    int checks = 0, errors = 0;

    control_unit_idex dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ValidE(ValidE),
`ifdef ILLEGAL_TRAP_EN
        .IllegalE(IllegalE),
`endif
        .PCSrcE(PCSrcE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] imm;
        logic       rw;
        logic [1:0] rs;
        logic       mw, j, b, as;
        logic [2:0] alu;
        logic       v, ill;
    } exp_t;

    exp_t q[$];
    exp_t st;

    function automatic exp_t bubble();
        exp_t e;
        e.imm = 0; e.rw = 0; e.rs = 0; e.mw = 0; e.j = 0; e.b = 0; e.as = 0; e.alu = 0; e.v = 0; e.ill = 0;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        string m;
        exp_t e;
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h03: m = (f3 == 3'd2) ? "lw" : "ill";
            7'h23: m = (f3 == 3'd2) ? "sw" : "ill";
            7'h33: m = (f3 == 3'd0) ? (ins[30] ? "sub" : "add") : (f3 == 3'd7) ? "and" : (f3 == 3'd6) ? "or" : "ill";
            7'h13: m = (f3 == 3'd0) ? "addi" : (f3 == 3'd7) ? "andi" : (f3 == 3'd6) ? "ori" : "ill";
            7'h63: m = (f3 == 3'd0) ? "beq" : "ill";
            7'h6f: m = "jal";
            default: m = "ill";
        endcase
        e = bubble();
        e.v = (m != "ill");
        e.ill = (m == "ill");
        case (m)
            "lw":   begin e.rw = 1; e.as = 1; e.rs = 2'b01; end
            "sw":   begin e.mw = 1; e.as = 1; e.imm = 2'b01; end
            "add":  e.rw = 1;
            "sub":  begin e.rw = 1; e.alu = 3'b001; end
            "and":  begin e.rw = 1; e.alu = 3'b010; end
            "or":   begin e.rw = 1; e.alu = 3'b011; end
            "addi": begin e.rw = 1; e.as = 1; end
            "andi": begin e.rw = 1; e.as = 1; e.alu = 3'b010; end
            "ori":  begin e.rw = 1; e.as = 1; e.alu = 3'b011; end
            "beq":  begin e.b = 1; e.imm = 2'b10; e.alu = 3'b001; end
            "jal":  begin e.j = 1; e.rw = 1; e.imm = 2'b11; e.rs = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, a, x, $time);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic s, input logic f, input logic z);
        InstrD = i; StallE = s; FlushE = f; ZeroE = z;
        @(posedge clk);
        if (rst) st = bubble();
        else if (f) st = bubble();
        else if (!s) st = model(i);
        q.push_back(st);
        #1;
    endtask

    task automatic asyncReset();
        @(negedge clk);
        #1 rst = 1; ZeroE = 1;
        #1;
        chk("rst_RegWriteE", RegWriteE, 0);
        chk("rst_ResultSrcE", ResultSrcE, 0);
        chk("rst_MemWriteE", MemWriteE, 0);
        chk("rst_JumpE", JumpE, 0);
        chk("rst_BranchE", BranchE, 0);
        chk("rst_ALUSrcE", ALUSrcE, 0);
        chk("rst_ALUControlE", ALUControlE, 0);
        chk("rst_ValidE", ValidE, 0);
        chk("rst_PCSrcE", PCSrcE, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("rst_IllegalE", IllegalE, 0);
`endif
        step(32'h003100B3, 0, 0, 0);
        rst = 0;
    endtask

    function automatic logic [31:0] rndInstr();
        logic [31:0] r;
        logic [6:0] ops [6];
        logic [2:0] f3s [4];
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        r = $urandom;
        if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) != 0) r[14:12] = f3s[$urandom_range(0, 3)];
        return r;
    endfunction

    // monitor: pop one expected E-stage state per cycle and compare all outputs
    always @(negedge clk) begin
        exp_t e, d;
        d = model(InstrD);
        chk("ImmSrcD", ImmSrcD, d.imm);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("RegWriteE", RegWriteE, e.rw);
            chk("ResultSrcE", ResultSrcE, e.rs);
            chk("MemWriteE", MemWriteE, e.mw);
            chk("JumpE", JumpE, e.j);
            chk("BranchE", BranchE, e.b);
            chk("ALUSrcE", ALUSrcE, e.as);
            chk("ALUControlE", ALUControlE, e.alu);
            chk("ValidE", ValidE, e.v);
            chk("PCSrcE", PCSrcE, e.v & (e.j | (e.b & ZeroE)));
`ifdef ILLEGAL_TRAP_EN
            chk("IllegalE", IllegalE, e.ill);
`endif
        end
    end

    initial begin
        st = bubble();
        step(32'h0, 0, 0, 0);
        step(32'h0, 0, 0, 0);
        rst = 0;
        step(32'h003100B3, 0, 0, 0);
        step(32'h403100B3, 0, 0, 0);
        step(32'h0000A283, 0, 0, 0);
        step(32'h0050A223, 0, 0, 0);
        step(32'h00000463, 0, 0, 0);
        step(32'h00000463, 0, 0, 1);
        step(32'h010000EF, 0, 0, 0);
        step(32'h003100B3, 0, 0, 0);
        step(32'h0050A223, 1, 0, 1);
        step(32'h0050A223, 1, 0, 0);
        step(32'h0050A223, 1, 1, 0);
        step(32'hFFFFFFFF, 0, 0, 0);
        step(32'h003100B3, 0, 0, 0);
        step(32'hFFFFFFFF, 0, 0, 0);
        step(32'h0050A223, 0, 1, 0);
        step(32'hFFFFFFFF, 0, 0, 0);
        step(32'hFFFFFFFF, 1, 0, 0);
        step(32'h010000EF, 0, 0, 0);
        asyncReset();
        step(32'h00000463, 1, 0, 1);
        asyncReset();
        for (int i = 0; i < 3000; i++)
            step(rndInstr(), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, 1'($urandom));
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
